wb_group_arbiter: RTL
=====================

Name: wb_group_arbiter

Overview:
- Round-robin arbiter that shares one register-file writeback port among NUM_UNITS multicycle execution units in a single writeback group.
- Sits between the unit result outputs and the register file / renamer writeback path, downstream of decode_and_issue.
- Grants one completing unit per cycle, acks it, and registers the winning result onto the writeback port.
- Keeps per-unit fairness with a rotating priority pointer.

Parameters:
- NUM_UNITS, 4, number of requesting units (2..8).
- DATA_WIDTH, 32, result width.
- ID_WIDTH, 3, instruction ID width.
- PHYS_ADDR_WIDTH, 6, physical rd address width.

Ports:
- clk  input  1  clock; all state updates on posedge clk.
- rst  input  1  reset. One clock; reset is synchronous and active-low. rst=0 resets.
- unit_done  input  NUM_UNITS  per-unit result valid; held with stable payload until acked.
- unit_id  input  NUM_UNITS*ID_WIDTH  packed per-unit instruction ID; unit i at [i*ID_WIDTH +: ID_WIDTH].
- unit_rd  input  NUM_UNITS*DATA_WIDTH  packed per-unit result data.
- unit_phys_rd  input  NUM_UNITS*PHYS_ADDR_WIDTH  packed per-unit physical destination.
- wb_hold  input  1  writeback blocked this cycle; no grant is issued.
- unit_ack  output  NUM_UNITS  one-hot grant; unit drops or replaces its result the next cycle.
- wb_valid  output  1  registered writeback valid.
- wb_id  output  ID_WIDTH  registered ID of the written-back instruction.
- wb_data  output  DATA_WIDTH  registered result.
- wb_phys_rd  output  PHYS_ADDR_WIDTH  registered physical rd.

Behaviour:
- State:
  - Priority pointer ptr, $clog2(NUM_UNITS) bits.
  - Output register {wb_valid, wb_id, wb_data, wb_phys_rd}.
- Reset (rst=0 at posedge): ptr=0, wb_valid=0, wb_id=0, wb_data=0, wb_phys_rd=0.
  - unit_ack is combinational and forced to 0 while rst=0.
- Grant (combinational):
  - Scan units ptr, ptr+1, …, wrapping mod NUM_UNITS.
  - The first unit with unit_done=1 wins, provided wb_hold=0 and rst=1.
  - unit_ack is one-hot for the winner, else all zero.
- Latency: the payload of the unit acked in cycle N appears on wb_* in cycle N+1 with wb_valid=1.
  - Back-to-back grants give one writeback per cycle.
- Output register update each cycle:
  - wb_valid <= |unit_ack.
  - If |unit_ack, load the winner's id/data/phys_rd.
  - Otherwise the payload registers hold their value; only wb_valid clears.
- Pointer update:
  - On grant to unit g: ptr <= (g+1) mod NUM_UNITS, which wraps from NUM_UNITS-1 to 0.
  - No grant: ptr unchanged.
  - For non-power-of-two NUM_UNITS, ptr never takes values ≥ NUM_UNITS.
- wb_hold=1:
  - No ack, ptr frozen, wb_valid=0 next cycle.
  - Pending unit_done remain pending.
- Simultaneous requests: exactly one ack per cycle. Every requester is served within NUM_UNITS grant cycles.
- Single requester with unit_done held: acked every cycle that wb_hold=0, with the pointer moving past it each time.
- Reset mid-operation:
  - A pending request is not acked during reset.
  - An in-flight wb_valid clears at the reset edge.
- A unit must not change its payload while unit_done=1 and unacked. This is a unit contract, not checked here.

Optional Feature:
- Macro: WB_GROUP_ARBITER_STATS_EN.
- Defined: adds outputs grant_count[31:0] and conflict_count[31:0].
  - Both reset to 0 on rst=0.
  - grant_count increments on every cycle with |unit_ack.
  - conflict_count increments on every cycle with ≥2 unit_done bits set and wb_hold=0.
  - Both counters wrap from 0xFFFFFFFF to 0.
- Undefined: these ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Reset with unit_done=4'b1111, rst=0 for 2 cycles → unit_ack=0, wb_valid=0; after release, first ack=4'b0001 and ptr becomes 1.
- unit_done=4'b1111 held 4 cycles with each acked unit's done reasserted → acks 0001,0010,0100,1000; wb_valid=1 in cycles 2–5 carrying ids of units 0,1,2,3.
- Only unit 3 requests (id=5, data=0xDEADBEEF, phys=0x2A) → ack=1000 same cycle; next cycle wb_valid=1, wb_id=5, wb_data=0xDEADBEEF, wb_phys_rd=0x2A; ptr wraps to 0.
- wb_hold=1 for 3 cycles with unit_done=4'b0101 → no acks, wb_valid=0, ptr unchanged; on release, ack goes to the lowest index ≥ ptr.
- Unit 2 requests, then rst=0 in the same cycle → no ack; next cycle wb_valid=0, ptr=0.
- With WB_GROUP_ARBITER_STATS_EN, run 10 cycles of unit_done=4'b0011 with no hold → grant_count=10, conflict_count=10.

Source files
------------

// File: rtl/wb_group_arbiter.sv
// wb_group_arbiter: round-robin arbiter that shares one register-file writeback port among
// NUM_UNITS multicycle execution units. One completing unit is acked per cycle. Its payload is
// registered onto the wb_* port, so it appears on that port the following cycle.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset (rst=0 resets)
//   unit_done       per-unit result valid, held with stable payload until acked
//   unit_id/rd/phys_rd  packed per-unit payload, unit i at [i*W +: W]
//   wb_hold         blocks granting this cycle
//   unit_ack        one-hot combinational grant
//   wb_valid/id/data/phys_rd  registered writeback
//   grant_count, conflict_count  present only with WB_GROUP_ARBITER_STATS_EN defined
//
// Optional feature macro: WB_GROUP_ARBITER_STATS_EN adds wrapping 32-bit grant and
// conflict counters.
module wb_group_arbiter #(
  parameter int unsigned NUM_UNITS       = 4,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ID_WIDTH        = 3,
  parameter int unsigned PHYS_ADDR_WIDTH = 6
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_UNITS-1:0]                 unit_done,
  input  logic [NUM_UNITS*ID_WIDTH-1:0]        unit_id,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0]      unit_rd,
  input  logic [NUM_UNITS*PHYS_ADDR_WIDTH-1:0] unit_phys_rd,
  input  logic                                 wb_hold,
  output logic [NUM_UNITS-1:0]                 unit_ack,
  output logic                                 wb_valid,
  output logic [ID_WIDTH-1:0]                  wb_id,
  output logic [DATA_WIDTH-1:0]                wb_data,
  output logic [PHYS_ADDR_WIDTH-1:0]           wb_phys_rd
`ifdef WB_GROUP_ARBITER_STATS_EN
  ,
  output logic [31:0]                          grant_count,
  output logic [31:0]                          conflict_count
`endif
);

  localparam int unsigned PtrWidth = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [PtrWidth-1:0]        ptr_q;
  logic [PtrWidth-1:0]        ptr_d;
  logic [PtrWidth-1:0]        grant_idx;
  logic [PtrWidth-1:0]        scan_idx;
  logic                       found;
  int unsigned                idx_sum;
  logic [ID_WIDTH-1:0]        sel_id;
  logic [DATA_WIDTH-1:0]      sel_data;
  logic [PHYS_ADDR_WIDTH-1:0] sel_phys;

  // Scan from ptr upward with wrap; the first requester wins.
  always_comb begin
    unit_ack  = '0;
    grant_idx = '0;
    scan_idx  = '0;
    idx_sum   = 0;
    found     = 1'b0;
    if (rst && !wb_hold) begin
      for (int unsigned k = 0; k < NUM_UNITS; k++) begin
        idx_sum = 32'(ptr_q) + k;
        if (idx_sum >= NUM_UNITS) idx_sum = idx_sum - NUM_UNITS;
        scan_idx = PtrWidth'(idx_sum);
        if (!found && unit_done[scan_idx]) begin
          found               = 1'b1;
          grant_idx           = scan_idx;
          unit_ack[scan_idx]  = 1'b1;
        end
      end
    end
  end

  // Explicit wrap keeps ptr inside 0..NUM_UNITS-1 for non-power-of-two unit counts.
  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (grant_idx == PtrWidth'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Payload mux driven directly by the one-hot ack.
  always_comb begin
    sel_id   = '0;
    sel_data = '0;
    sel_phys = '0;
    for (int i = 0; i < int'(NUM_UNITS); i++) begin
      if (unit_ack[i]) begin
        sel_id   = unit_id[i*ID_WIDTH +: ID_WIDTH];
        sel_data = unit_rd[i*DATA_WIDTH +: DATA_WIDTH];
        sel_phys = unit_phys_rd[i*PHYS_ADDR_WIDTH +: PHYS_ADDR_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q      <= '0;
      wb_valid   <= 1'b0;
      wb_id      <= '0;
      wb_data    <= '0;
      wb_phys_rd <= '0;
    end else begin
      ptr_q    <= ptr_d;
      wb_valid <= found;
      // Payload holds when there is no grant; only wb_valid drops.
      if (found) begin
        wb_id      <= sel_id;
        wb_data    <= sel_data;
        wb_phys_rd <= sel_phys;
      end
    end
  end

`ifdef WB_GROUP_ARBITER_STATS_EN
  logic conflict;
  assign conflict = ($countones(unit_done) >= 2) && !wb_hold;

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_count    <= '0;
      conflict_count <= '0;
    end else begin
      if (found)    grant_count    <= grant_count + 32'd1;
      if (conflict) conflict_count <= conflict_count + 32'd1;
    end
  end
`endif

endmodule
